// File: rtl/memory_arbiter_pkg.sv
// Shared types for the memory data-port arbiter.
//   arbiter_state_t : arbitration FSM states.
//   mem_request_t   : one master's access as presented to the memory port.
package memory_arbiter_pkg;

  // Widest word address that fits a 32-bit byte address space.
  localparam int unsigned MemAddrMax = 30;

  typedef enum logic [0:0] {
    ARBITRATE,
    LOCKED
  } arbiter_state_t;

  typedef struct packed {
    logic                  write;
    logic [3:0]            byte_en;
    logic [MemAddrMax-1:0] address;
    logic [31:0]           data;
  } mem_request_t;

endpackage

// File: rtl/memory_port_arbiter_if.sv
// Requester-side and memory-side signals of the memory data-port arbiter.
//   slave  : seen by the arbiter (takes requests, drives grants/responses and the memory port).
//   master : seen by the requesters and the memory model.
interface memory_port_arbiter_if #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned ADDR_WIDTH  = 8
);
  logic [NUM_MASTERS-1:0]                 req_i;
  logic [NUM_MASTERS-1:0]                 write_i;
  logic [NUM_MASTERS-1:0]                 lock_i;
  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] address_i;
  logic [NUM_MASTERS-1:0][31:0]           data_i;
  logic [NUM_MASTERS-1:0][3:0]            byte_en_i;
  logic [NUM_MASTERS-1:0]                 grant_o;
  logic [NUM_MASTERS-1:0]                 rvalid_o;
  logic [NUM_MASTERS-1:0]                 wdone_o;
  logic [31:0]                            rdata_o;
  logic                                   mem_enable_o;
  logic [3:0]                             mem_write_o;
  logic [ADDR_WIDTH-1:0]                  mem_address_o;
  logic [31:0]                            mem_data_o;
  logic [31:0]                            mem_data_i;

  modport slave (
    input  req_i, write_i, lock_i, address_i, data_i, byte_en_i, mem_data_i,
    output grant_o, rvalid_o, wdone_o, rdata_o,
    output mem_enable_o, mem_write_o, mem_address_o, mem_data_o
  );

  modport master (
    output req_i, write_i, lock_i, address_i, data_i, byte_en_i, mem_data_i,
    input  grant_o, rvalid_o, wdone_o, rdata_o,
    input  mem_enable_o, mem_write_o, mem_address_o, mem_data_o
  );
endinterface

// File: rtl/round_robin_picker.sv
// Combinational round-robin winner selection.
//   req_i        : request vector.
//   rr_ptr_i     : index of the last winner; the search starts one above it and wraps.
//   winner_oh_o  : one-hot winner (all zero when nobody requests).
//   winner_idx_o : index of the winner (0 when nobody requests).
module round_robin_picker #(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IdxW-1:0]    rr_ptr_i,
  output logic [NUM_REQ-1:0] winner_oh_o,
  output logic [IdxW-1:0]    winner_idx_o
);

  logic        found;
  int unsigned cand;

  always_comb begin
    found        = 1'b0;
    cand         = 0;
    winner_oh_o  = '0;
    winner_idx_o = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      // Wrap by subtraction so non-power-of-two counts work.
      cand = 32'(rr_ptr_i) + off;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!found && req_i[IdxW'(cand)]) begin
        found                     = 1'b1;
        winner_oh_o[IdxW'(cand)]  = 1'b1;
        winner_idx_o              = IdxW'(cand);
      end
    end
  end

endmodule

// File: rtl/memory_port_arbiter.sv
// Round-robin arbiter for the on-chip memory data port, with bounded burst lock.
//   clk_i   : clock.
//   rst_n_i : asynchronous active-low reset.
//   bus     : requester handshake (req/write/lock/address/data/byte_en in, grant/rvalid/wdone/
//             rdata out) and memory port drive (enable, byte strobes, address, write data,
//             read data in).
module memory_port_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned MAX_BURST   = 4
) (
  input logic                  clk_i,
  input logic                  rst_n_i,
  memory_port_arbiter_if.slave bus
);

  localparam int unsigned PtrW = $clog2(NUM_MASTERS);
  localparam int unsigned CntW = $clog2(MAX_BURST + 1);

  arbiter_state_t         state_q;
  logic [PtrW-1:0]        rr_ptr_q;
  logic [PtrW-1:0]        owner_q;
  logic [CntW-1:0]        burst_cnt_q;
  logic [NUM_MASTERS-1:0] rvalid_q;
  logic [NUM_MASTERS-1:0] wdone_q;

  logic [NUM_MASTERS-1:0] pick_oh;
  logic [PtrW-1:0]        pick_idx;
  logic [NUM_MASTERS-1:0] grant;
  logic [PtrW-1:0]        gnt_idx;
  logic                   any_grant;
  mem_request_t           sel;
  logic                   unused_addr_hi;

  round_robin_picker #(
    .NUM_REQ (NUM_MASTERS)
  ) u_picker (
    .req_i        (bus.req_i),
    .rr_ptr_i     (rr_ptr_q),
    .winner_oh_o  (pick_oh),
    .winner_idx_o (pick_idx)
  );

  // Grant is combinational with req; forced off while reset is held.
  always_comb begin
    grant   = '0;
    gnt_idx = pick_idx;
    unique case (state_q)
      ARBITRATE: grant = pick_oh;
      LOCKED: begin
        gnt_idx = owner_q;
        if (bus.req_i[owner_q]) begin
          grant[owner_q] = 1'b1;
        end
      end
      default: ;
    endcase
    if (!rst_n_i) begin
      grant = '0;
    end
  end

  assign any_grant = |grant;

  always_comb begin
    sel = '0;
    if (any_grant) begin
      sel.write   = bus.write_i[gnt_idx];
      sel.byte_en = bus.byte_en_i[gnt_idx];
      sel.address = MemAddrMax'(bus.address_i[gnt_idx]);
      sel.data    = bus.data_i[gnt_idx];
    end
  end

  assign unused_addr_hi    = ^sel.address;
  assign bus.grant_o       = grant;
  assign bus.mem_enable_o  = any_grant;
  assign bus.mem_write_o   = sel.write ? sel.byte_en : 4'b0000;
  assign bus.mem_address_o = sel.address[ADDR_WIDTH-1:0];
  assign bus.mem_data_o    = sel.data;
  assign bus.rdata_o       = bus.mem_data_i;
  assign bus.rvalid_o      = rvalid_q;
  assign bus.wdone_o       = wdone_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ARBITRATE;
      rr_ptr_q    <= PtrW'(NUM_MASTERS - 1);
      owner_q     <= '0;
      burst_cnt_q <= '0;
      rvalid_q    <= '0;
      wdone_q     <= '0;
    end else begin
      // One-cycle response pulse for the access granted this cycle.
      rvalid_q <= '0;
      wdone_q  <= '0;
      if (any_grant) begin
        rr_ptr_q <= gnt_idx;
        if (sel.write) begin
          wdone_q[gnt_idx] <= 1'b1;
        end else begin
          rvalid_q[gnt_idx] <= 1'b1;
        end
      end

      unique case (state_q)
        ARBITRATE: begin
          if (any_grant && bus.lock_i[gnt_idx] && (MAX_BURST > 1)) begin
            state_q     <= LOCKED;
            owner_q     <= gnt_idx;
            burst_cnt_q <= CntW'(1);
          end else begin
            burst_cnt_q <= '0;
          end
        end
        LOCKED: begin
          if (bus.req_i[owner_q] && bus.lock_i[owner_q]) begin
            burst_cnt_q <= burst_cnt_q + CntW'(1);
            if (burst_cnt_q + CntW'(1) == CntW'(MAX_BURST)) begin
              state_q <= ARBITRATE;
            end
          end else begin
            // Lock released or owner idle: end the burst (idle owner costs one bubble).
            state_q     <= ARBITRATE;
            burst_cnt_q <= '0;
          end
        end
        default: state_q <= ARBITRATE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_port_arbiter.sv
module tb_memory_port_arbiter;
  logic clk;
  logic rst_n;

  int n_total = 0;
  int n_bad   = 0;

  logic [3:0]  be0   = 4'b1100;
  logic [3:0]  be1   = 4'b0011;
  logic [7:0]  addr0 = 8'h15;
  logic [7:0]  addr1 = 8'h2A;
  logic [31:0] dat0  = 32'h0BAD_F00D;
  logic [31:0] dat1  = 32'hDEAD_BEEF;

  logic [3:0] resp_q[$];

  memory_port_arbiter_if #(.NUM_MASTERS(2), .ADDR_WIDTH(8)) mif ();

  memory_port_arbiter #(
    .NUM_MASTERS (2),
    .ADDR_WIDTH  (8),
    .MAX_BURST   (4)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (mif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic apply_data();
    mif.byte_en_i[0] = be0;
    mif.byte_en_i[1] = be1;
    mif.address_i[0] = addr0;
    mif.address_i[1] = addr1;
    mif.data_i[0]    = dat0;
    mif.data_i[1]    = dat1;
  endtask

  // Starts and ends at a negedge: drives one cycle, checks the grant-cycle outputs,
  // then checks the response one cycle later via the scoreboard.
  task automatic step(input string tag, input logic [1:0] req, input logic [1:0] lock,
                      input logic [1:0] wr, input logic [1:0] exp_gnt, input int exp_cnt);
    logic [3:0]  exp_resp;
    logic [3:0]  exp_mw;
    logic [7:0]  exp_addr;
    logic [31:0] exp_data;
    apply_data();
    mif.req_i      = req;
    mif.lock_i     = lock;
    mif.write_i    = wr;
    mif.mem_data_i = $urandom();
    exp_addr = exp_gnt[1] ? addr1 : (exp_gnt[0] ? addr0 : 8'h00);
    exp_data = exp_gnt[1] ? dat1 : (exp_gnt[0] ? dat0 : 32'h0);
    exp_mw   = 4'b0000;
    if ((exp_gnt & wr) != 2'b00) exp_mw = exp_gnt[1] ? be1 : be0;
    #1;
    check_val({tag, "/grant"}, 32'(mif.grant_o), 32'(exp_gnt));
    check_val({tag, "/burst_cnt"}, 32'(dut.burst_cnt_q), exp_cnt);
    check_val({tag, "/mem_en"}, 32'(mif.mem_enable_o), 32'(|exp_gnt));
    check_val({tag, "/mem_wr"}, 32'(mif.mem_write_o), 32'(exp_mw));
    check_val({tag, "/mem_addr"}, 32'(mif.mem_address_o), 32'(exp_addr));
    check_val({tag, "/mem_data"}, mif.mem_data_o, exp_data);
    resp_q.push_back({exp_gnt & wr, exp_gnt & ~wr});
    @(posedge clk);
    #1;
    exp_resp = resp_q.pop_front();
    check_val({tag, "/resp"}, 32'({mif.wdone_o, mif.rvalid_o}), 32'(exp_resp));
    if (exp_resp[1:0] != 2'b00) check_val({tag, "/rdata"}, mif.rdata_o, mif.mem_data_i);
    @(negedge clk);
  endtask

  initial begin
    rst_n          = 1'b0;
    mif.req_i      = 2'b11;
    mif.lock_i     = 2'b00;
    mif.write_i    = 2'b00;
    mif.mem_data_i = 32'h0;
    apply_data();

    // Reset held with both masters requesting.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check_val("rst/grant", 32'(mif.grant_o), 32'h0);
      check_val("rst/rvalid", 32'(mif.rvalid_o), 32'h0);
      check_val("rst/mem_en", 32'(mif.mem_enable_o), 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step("rel", 2'b11, 2'b00, 2'b00, 2'b01, 0);

    // Fairness.
    step("fair1", 2'b11, 2'b00, 2'b00, 2'b10, 0);
    step("fair2", 2'b11, 2'b00, 2'b00, 2'b01, 0);
    step("fair3", 2'b11, 2'b00, 2'b00, 2'b10, 0);

    // Lock burst by master 1 (lock outside its grant cycle is ignored).
    step("lk0", 2'b11, 2'b10, 2'b00, 2'b01, 0);
    step("lk1", 2'b11, 2'b10, 2'b00, 2'b10, 0);
    step("lk2", 2'b11, 2'b10, 2'b00, 2'b10, 1);
    step("lk3", 2'b11, 2'b10, 2'b00, 2'b10, 2);
    step("lk4", 2'b11, 2'b10, 2'b00, 2'b10, 3);
    step("lk_end", 2'b11, 2'b10, 2'b00, 2'b01, 4);

    // Owner idle: master 0 locks then drops its request.
    step("idl0", 2'b10, 2'b00, 2'b00, 2'b10, 0);
    step("idl1", 2'b11, 2'b01, 2'b00, 2'b01, 0);
    step("idl_bub", 2'b10, 2'b00, 2'b00, 2'b00, 1);
    step("idl2", 2'b10, 2'b00, 2'b00, 2'b10, 0);

    // Store paths, including a store with no byte strobes.
    be1 = 4'b0011;
    step("st1", 2'b10, 2'b00, 2'b10, 2'b10, 0);
    be0 = 4'b0000;
    step("st0_nobe", 2'b01, 2'b00, 2'b01, 2'b01, 0);
    be0 = 4'b1100;

    // Reset during master 0's third locked access.
    step("mr1", 2'b01, 2'b01, 2'b00, 2'b01, 0);
    step("mr2", 2'b01, 2'b01, 2'b00, 2'b01, 1);
    mif.req_i  = 2'b01;
    mif.lock_i = 2'b01;
    #1;
    check_val("mr3/grant", 32'(mif.grant_o), 32'h1);
    check_val("mr3/burst_cnt", 32'(dut.burst_cnt_q), 32'd2);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("mr3/grant_in_rst", 32'(mif.grant_o), 32'h0);
    check_val("mr3/mem_en_in_rst", 32'(mif.mem_enable_o), 32'h0);
    @(posedge clk);
    #1;
    check_val("mr3/resp", 32'({mif.wdone_o, mif.rvalid_o}), 32'h0);
    check_val("mr3/burst_cnt_rst", 32'(dut.burst_cnt_q), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst", 2'b11, 2'b00, 2'b00, 2'b01, 0);
    step("post_nolock", 2'b11, 2'b00, 2'b00, 2'b10, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
